// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline: load-use stalls,
// taken-branch flushes resolved at EX/MEM, and a data-memory handshake that freezes the pipe.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ifid,
  input  logic [4:0]       rs2_ifid,
  input  logic [4:0]       rd_idex,
  input  logic             memread_idex,
  input  logic             branch_exmem,
  input  logic             zero_exmem,
  input  logic             memread_exmem,
  input  logic             memwrite_exmem,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pcsrc,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             flush_exmem,
  output logic             freeze,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;
  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic in_wait;
  logic access;
  logic taken;
  logic load_use;
  logic wait_start;
  logic branch_go;
  logic load_use_go;

  // Hazard decode and control outputs; everything here is purely combinational.
  always_comb begin
    in_wait     = (state_q == ST_MEM_WAIT);
    access      = memread_exmem | memwrite_exmem;
    taken       = branch_exmem & zero_exmem;
    load_use    = memread_idex & (rd_idex != 5'd0) &
                  ((rd_idex == rs1_ifid) | (rd_idex == rs2_ifid));
    wait_start  = !in_wait & access & !mem_ready;
    // A branch sharing its EX/MEM slot with a stalled access waits until the access completes.
    branch_go   = taken & !in_wait & !wait_start;
    load_use_go = load_use & !taken & !in_wait;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    mem_req     = 1'b0;
    pcsrc       = 1'b0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    flush_exmem = 1'b0;
    freeze      = 1'b0;

    if (rst_n) begin
      mem_req     = in_wait | access;
      freeze      = in_wait;
      pcsrc       = branch_go;
      flush_ifid  = branch_go;
      flush_exmem = branch_go;
      stall_pc    = load_use_go;
      stall_ifid  = load_use_go;
      bubble_idex = branch_go | load_use_go;
    end
  end

  // Memory handshake FSM, timeout tracking and stall accounting.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (wait_start) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_VAL) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    if ((freeze | stall_pc) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout_err = err_q;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: hazards, branch flush,
// memory handshake, timeout and reset behaviour with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_ifid, rs2_ifid, rd_idex;
  logic        memread_idex, branch_exmem, zero_exmem;
  logic        memread_exmem, memwrite_exmem, mem_ready;
  logic        mem_req, pcsrc, stall_pc, stall_ifid, bubble_idex;
  logic        flush_ifid, flush_exmem, freeze, mem_timeout_err;
  logic [15:0] stall_cnt;
  logic [7:0]  ctrl;

  int checks = 0;
  int errors = 0;
  int frozen;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_ifid       (rs1_ifid),
    .rs2_ifid       (rs2_ifid),
    .rd_idex        (rd_idex),
    .memread_idex   (memread_idex),
    .branch_exmem   (branch_exmem),
    .zero_exmem     (zero_exmem),
    .memread_exmem  (memread_exmem),
    .memwrite_exmem (memwrite_exmem),
    .mem_ready      (mem_ready),
    .mem_req        (mem_req),
    .pcsrc          (pcsrc),
    .stall_pc       (stall_pc),
    .stall_ifid     (stall_ifid),
    .bubble_idex    (bubble_idex),
    .flush_ifid     (flush_ifid),
    .flush_exmem    (flush_exmem),
    .freeze         (freeze),
    .mem_timeout_err(mem_timeout_err),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  // Bit order: mem_req pcsrc stall_pc stall_ifid bubble_idex flush_ifid flush_exmem freeze
  assign ctrl = {mem_req, pcsrc, stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_exmem, freeze};

  localparam logic [7:0] C_IDLE   = 8'b0000_0000;
  localparam logic [7:0] C_LU     = 8'b0011_1000;
  localparam logic [7:0] C_BRANCH = 8'b0100_1110;
  localparam logic [7:0] C_REQ    = 8'b1000_0000;
  localparam logic [7:0] C_FROZEN = 8'b1000_0001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_ifid = 5'd0; rs2_ifid = 5'd0; rd_idex = 5'd0;
    memread_idex = 1'b0; branch_exmem = 1'b0; zero_exmem = 1'b0;
    memread_exmem = 1'b0; memwrite_exmem = 1'b0; mem_ready = 1'b0;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset with every hazard source asserted: outputs must be forced low.
    next_cycle();
    memread_exmem = 1'b1; branch_exmem = 1'b1; zero_exmem = 1'b1;
    memread_idex = 1'b1; rd_idex = 5'd5; rs1_ifid = 5'd5;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rst_err", 32'(mem_timeout_err), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);

    next_cycle();
    rst_n = 1'b1;
    #1 check("idle_ctrl", 32'(ctrl), 32'(C_IDLE));

    // Load-use via rs2, then rd=x0, then plain register match without a load, then via rs1.
    next_cycle();
    memread_idex = 1'b1; rd_idex = 5'd5; rs2_ifid = 5'd5; rs1_ifid = 5'd1;
    #1 check("lu_rs2", 32'(ctrl), 32'(C_LU));
    next_cycle();
    memread_idex = 1'b1; rd_idex = 5'd0;
    #1 check("lu_x0", 32'(ctrl), 32'(C_IDLE));
    check("cnt_after_lu", 32'(stall_cnt), 32'd1);
    next_cycle();
    rd_idex = 5'd7; rs1_ifid = 5'd7;
    #1 check("no_load", 32'(ctrl), 32'(C_IDLE));
    next_cycle();
    memread_idex = 1'b1; rd_idex = 5'd7; rs1_ifid = 5'd7;
    #1 check("lu_rs1", 32'(ctrl), 32'(C_LU));

    // Taken branch, not-taken branch, branch beating a simultaneous load-use.
    next_cycle();
    branch_exmem = 1'b1; zero_exmem = 1'b1;
    #1 check("br_taken", 32'(ctrl), 32'(C_BRANCH));
    next_cycle();
    branch_exmem = 1'b1; zero_exmem = 1'b0;
    #1 check("br_not_taken", 32'(ctrl), 32'(C_IDLE));
    next_cycle();
    branch_exmem = 1'b1; zero_exmem = 1'b1;
    memread_idex = 1'b1; rd_idex = 5'd9; rs2_ifid = 5'd9;
    #1 check("br_over_lu", 32'(ctrl), 32'(C_BRANCH));
    next_cycle();
    #1 check("cnt_after_br", 32'(stall_cnt), 32'd2);

    // Zero-wait store: request, no freeze, FSM stays in RUN.
    next_cycle();
    memwrite_exmem = 1'b1; mem_ready = 1'b1;
    #1 check("store_0wait", 32'(ctrl), 32'(C_REQ));
    next_cycle();
    #1 check("store_after", 32'(ctrl), 32'(C_IDLE));

    // Fresh counters, then a load answered on the third MEM_WAIT cycle.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    memread_exmem = 1'b1;
    #1 check("ld_issue", 32'(ctrl), 32'(C_REQ));
    next_cycle();
    memread_exmem = 1'b1;
    memread_idex = 1'b1; rd_idex = 5'd3; rs1_ifid = 5'd3;
    #1 check("ld_wait1_lu_masked", 32'(ctrl), 32'(C_FROZEN));
    next_cycle();
    memread_exmem = 1'b1;
    #1 check("ld_wait2", 32'(ctrl), 32'(C_FROZEN));
    next_cycle();
    memread_exmem = 1'b1; mem_ready = 1'b1;
    #1 check("ld_wait3_ready", 32'(ctrl), 32'(C_FROZEN));
    next_cycle();
    #1 check("ld_done", 32'(ctrl), 32'(C_IDLE));
    check("ld_cnt", 32'(stall_cnt), 32'd3);
    check("ld_err", 32'(mem_timeout_err), 32'd0);

    // Load that never completes: frozen for exactly 15 cycles, then sticky error.
    next_cycle();
    memread_exmem = 1'b1;
    #1 check("to_issue", 32'(ctrl), 32'(C_REQ));
    frozen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (!freeze) break;
      frozen++;
    end
    check("to_frozen_cycles", frozen, 32'd15);
    check("to_err", 32'(mem_timeout_err), 32'd1);
    check("to_cnt", 32'(stall_cnt), 32'd18);
    idle_inputs();
    #1 check("to_run_ctrl", 32'(ctrl), 32'(C_IDLE));
    next_cycle();
    next_cycle();
    #1 check("to_err_sticky", 32'(mem_timeout_err), 32'd1);

    // Reset in the middle of MEM_WAIT.
    next_cycle();
    memread_exmem = 1'b1;
    next_cycle();
    memread_exmem = 1'b1;
    #1 check("rw_frozen", 32'(ctrl), 32'(C_FROZEN));
    next_cycle();
    memread_exmem = 1'b1;
    rst_n = 1'b0;
    #1 check("rw_rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    next_cycle();
    rst_n = 1'b1;
    #1 check("rw_after_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rw_after_err", 32'(mem_timeout_err), 32'd0);
    check("rw_after_cnt", 32'(stall_cnt), 32'd0);
    next_cycle();
    memread_exmem = 1'b1;
    #1 check("rw_state_run", 32'(ctrl), 32'(C_REQ));

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
